// File: rtl/axi_lite_arbiter_pkg.sv
// axi_lite_arbiter_pkg
//   Shared definitions for the 2-master / 1-slave AXI-lite arbiter:
//   bus-width macros, the arbiter state enum, AXI response codes and the
//   grant decision record passed from the grant logic to the top.
//   Optional build macro used by the arbiter files: AXI_ARB_RR_EN
//   (round-robin arbitration instead of fixed m1-first priority).

`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 32
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 32
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 2
`endif

package axi_lite_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } arb_state_e;

  localparam logic [`AXI_RESP_BUS-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [`AXI_RESP_BUS-1:0] AXI_RESP_SLVERR = 2'b10;

  // Outcome of one arbitration round.
  typedef struct packed {
    logic valid;  // at least one master is requesting
    logic owner;  // winning master index
    logic write;  // winner is issuing a write (AW and W both valid)
  } grant_t;

endpackage

// File: rtl/axi_lite_arb_grant.sv
// axi_lite_arb_grant
//   Combinational request -> winner selection for the arbiter.
//   Ports:
//     rd_req[1:0]   per-master read request (arvalid)
//     wr_req[1:0]   per-master write request (awvalid & wvalid)
//     last_owner    most recently granted master (only with AXI_ARB_RR_EN)
//     grant         valid / owner / write decision
//   Build macro: AXI_ARB_RR_EN selects round-robin; otherwise m1 always
//   wins when both masters request.

module axi_lite_arb_grant
  import axi_lite_arbiter_pkg::*;
(
  input  logic [1:0] rd_req,
  input  logic [1:0] wr_req,
`ifdef AXI_ARB_RR_EN
  input  logic       last_owner,
`endif
  output grant_t     grant
);

  logic [1:0] req;
  logic       win;

  always_comb begin
    req = rd_req | wr_req;
    win = 1'b0;
    if (req[0] && req[1]) begin
`ifdef AXI_ARB_RR_EN
      win = ~last_owner;
`else
      win = 1'b1;
`endif
    end else begin
      win = req[1];
    end
    grant.valid = |req;
    grant.owner = win;
    // Within one master a complete write request beats its read request.
    grant.write = wr_req[win];
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter
//   Two AXI-lite masters (m0 = fetch, m1 = LSU) share one AXI-lite slave.
//   One transaction is in flight at a time; the grant is registered so no
//   master valid reaches the slave in the same cycle it is raised.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     m0_* / m1_*                 full AXI-lite slave ports toward masters
//     s_*                         AXI-lite master port toward the memory
//   Build macro: AXI_ARB_RR_EN enables round-robin arbitration (adds the
//   last_owner register); default is fixed priority with m1 first.

module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = `AXI_ADDR_BUS,
  parameter int DATA_W = `AXI_DATA_BUS
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  // master 1
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // slave
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  arb_state_e state;
  logic       owner;
  logic       aw_done;
  logic       w_done;
`ifdef AXI_ARB_RR_EN
  logic       last_owner;
`endif

  logic [1:0] rd_req;
  logic [1:0] wr_req;
  grant_t     grant;

  assign rd_req = {m1_arvalid, m0_arvalid};
  assign wr_req = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};

  axi_lite_arb_grant u_grant (
    .rd_req     (rd_req),
    .wr_req     (wr_req),
`ifdef AXI_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .grant      (grant)
  );

  // Owner-selected master signals.
  logic sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
  // Owner-side responses before being steered to one master.
  logic ar_ready, r_valid, aw_ready, w_ready, b_valid;

  always_comb begin
    sel_arvalid = owner ? m1_arvalid : m0_arvalid;
    sel_rready  = owner ? m1_rready  : m0_rready;
    sel_awvalid = owner ? m1_awvalid : m0_awvalid;
    sel_wvalid  = owner ? m1_wvalid  : m0_wvalid;
    sel_bready  = owner ? m1_bready  : m0_bready;

    // Address/data toward the slave follow owner regardless of valid.
    s_araddr = owner ? m1_araddr : m0_araddr;
    s_awaddr = owner ? m1_awaddr : m0_awaddr;
    s_wdata  = owner ? m1_wdata  : m0_wdata;
    s_wstrb  = owner ? m1_wstrb  : m0_wstrb;

    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;

    case (state)
      RD_ADDR: begin
        s_arvalid = sel_arvalid;
        ar_ready  = s_arready;
      end
      RD_DATA: begin
        r_valid  = s_rvalid;
        s_rready = sel_rready;
      end
      WR_ADDR: begin
        // A channel that already handshook is masked on both sides so it
        // cannot fire twice while the other channel is still waiting.
        s_awvalid = sel_awvalid & ~aw_done;
        aw_ready  = s_awready   & ~aw_done;
        s_wvalid  = sel_wvalid  & ~w_done;
        w_ready   = s_wready    & ~w_done;
      end
      WR_RESP: begin
        b_valid  = s_bvalid;
        s_bready = sel_bready;
      end
      default: ;
    endcase

    m0_arready = ar_ready & ~owner;
    m1_arready = ar_ready &  owner;
    m0_rvalid  = r_valid  & ~owner;
    m1_rvalid  = r_valid  &  owner;
    m0_awready = aw_ready & ~owner;
    m1_awready = aw_ready &  owner;
    m0_wready  = w_ready  & ~owner;
    m1_wready  = w_ready  &  owner;
    m0_bvalid  = b_valid  & ~owner;
    m1_bvalid  = b_valid  &  owner;
  end

  // Responses pass through untouched; only the valids are steered.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;
  assign m0_bresp = s_bresp;
  assign m1_bresp = s_bresp;

  logic aw_fin, w_fin;
  assign aw_fin = aw_done | (s_awvalid & s_awready);
  assign w_fin  = w_done  | (s_wvalid  & s_wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef AXI_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant.valid) begin
            owner <= grant.owner;
            state <= grant.write ? WR_ADDR : RD_ADDR;
`ifdef AXI_ARB_RR_EN
            last_owner <= grant.owner;
`endif
          end
        end
        RD_ADDR: if (s_arvalid && s_arready) state <= RD_DATA;
        RD_DATA: if (s_rvalid && s_rready) state <= IDLE;
        WR_ADDR: begin
          if (aw_fin && w_fin) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WR_RESP: if (s_bvalid && s_bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- 2-master / 1-slave AXI-lite arbiter sitting between the core's bus masters and a single shared memory slave.
- m0 = fetch unit (instruction reads), m1 = LSU (data reads/writes).
- Exactly one transaction is in flight at a time.
- The slave sees a single AXI-lite master; each master sees a private AXI-lite slave.

Parameters:
- ADDR_W, 32, address width (matches `AXI_ADDR_BUS)
- DATA_W, 32, data width (matches `AXI_DATA_BUS); strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mX_araddr in ADDR_W; mX_arvalid in 1; mX_arready out 1: AR channel, X∈{0,1}
- mX_rdata out DATA_W; mX_rresp out 2; mX_rvalid out 1; mX_rready in 1: R channel
- mX_awaddr in ADDR_W; mX_awvalid in 1; mX_awready out 1: AW channel
- mX_wdata in DATA_W; mX_wstrb in DATA_W/8; mX_wvalid in 1; mX_wready out 1: W channel
- mX_bresp out 2; mX_bvalid out 1; mX_bready in 1: B channel
- s_araddr, s_arvalid out; s_arready in: slave AR
- s_rdata, s_rresp, s_rvalid in; s_rready out: slave R
- s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid out; s_awready, s_wready in: slave AW/W
- s_bresp, s_bvalid in; s_bready out: slave B

Behaviour:
- Registers:
  - state ∈ {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP}
  - owner (1 bit)
  - aw_done, w_done
- Reset: state=IDLE, owner=0, flags=0.
- All valid/ready outputs to both masters and to the slave are 0 while state is IDLE, and on the cycle after rst.
- IDLE, request detection:
  - Master X requests if mX_arvalid, or if mX_awvalid&mX_wvalid.
  - A write needs AW and W valid in the same cycle before it is granted.
  - The winner is latched into owner. A read goes to RD_ADDR; a write goes to WR_ADDR.
  - Within one master, a write beats a read in the same cycle.
  - Between masters, fixed priority: m1 over m0 (see Optional Feature).
  - Grant costs exactly 1 cycle; no combinational path from mX_*valid to s_*valid.
- RD_ADDR:
  - s_araddr = m[owner]_araddr; s_arvalid = m[owner]_arvalid; m[owner]_arready = s_arready.
  - On s_arvalid&s_arready go to RD_DATA.
- RD_DATA:
  - R channel routed to owner: m[owner]_rvalid = s_rvalid, s_rready = m[owner]_rready.
  - On the R handshake go to IDLE.
- WR_ADDR:
  - AW and W are routed independently. s_awvalid is gated by !aw_done; s_wvalid is gated by !w_done.
  - aw_done and w_done set on their handshakes.
  - When both are done (including the same cycle), go to WR_RESP and clear both flags.
- WR_RESP:
  - B channel routed to owner; on the B handshake go to IDLE.
- Non-owner isolation:
  - The non-owner master sees arready/awready/wready/rvalid/bvalid = 0.
  - Its requests stay pending; AXI requires it to hold valid.
- Data fields: s_* data/address outputs are muxed by owner even when valid is low; this is don't-care.
- Slave back-pressure: unbounded stall in any state is legal and holds state.
- Reset mid-transaction: returns to IDLE the next cycle. The in-flight transaction is abandoned; the slave must also be reset.
- Response passthrough: rresp and bresp pass through unmodified, including SLVERR.
- Back-to-back: a master is re-granted no earlier than the cycle after its terminal handshake. Minimum 3 cycles per read when the slave responds with zero wait.

Optional Feature:
- Macro: AXI_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_owner register (reset 0) records the master granted most recently. On simultaneous requests, the other master wins.
- Undefined: fixed priority, m1 always wins on simultaneous requests; last_owner is not instantiated.

Decomposition:
- Shared package/defines file carries:
  - the state enum typedef arb_state_e
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10
  - the existing `AXI_ADDR_BUS/`AXI_DATA_BUS/`AXI_RESP_BUS macros
- One sub-module is natural: axi_lite_arb_grant, the combinational request→winner logic including the RR option. Everything else stays flat.

Test Plan:
- m0 read 0x8000_0000, slave zero-wait, rdata 0xDEAD_BEEF → m0 sees rvalid with 0xDEAD_BEEF and rresp 0; m1 sees no valid; 3-cycle turnaround.
- m0 arvalid and m1 arvalid asserted in the same cycle (fixed priority) → m1 served first, then m0 served without deasserting; s_araddr order is m1 then m0.
- Same stimulus with AXI_ARB_RR_EN, two rounds → grant order m1, m0, m1, m0.
- m1 write 0x8000_0100, data 0x1234_5678, wstrb 4'b0011; slave asserts awready 2 cycles before wready → exactly one AW and one W handshake; one B routed to m1; state returns to IDLE.
- Slave returns SLVERR on an m0 read with 5 wait cycles on rvalid → m0_rresp=2'b10; all other outputs held stable while stalled.
- rst asserted while in RD_DATA → next cycle: IDLE, all valids/readies 0; a fresh m0 read then completes normally.
